// File: rtl/gc_pkg.sv
// Shared types and constants for the GameCube controller report decoder.
// Field positions and button ordering live here so the decoder and its stick calibrators agree.
package gc_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CALIB = 2'd1,
    ST_RUN   = 2'd2
  } gc_state_t;

  localparam logic [7:0] STICK_NEUTRAL = 8'h80;

  // Bit positions inside the Buttons output word
  localparam int BTN_Y      = 0;
  localparam int BTN_X      = 1;
  localparam int BTN_B      = 2;
  localparam int BTN_A      = 3;
  localparam int BTN_L      = 4;
  localparam int BTN_R      = 5;
  localparam int BTN_DLEFT  = 6;
  localparam int BTN_DUP    = 7;
  localparam int BTN_DDOWN  = 8;
  localparam int BTN_DRIGHT = 9;
  localparam int BTN_Z      = 10;
  localparam int BTN_START  = 11;

  // Bit positions inside the raw 64-bit report
  localparam int RPT_START  = 60;
  localparam int RPT_Y      = 59;
  localparam int RPT_X      = 58;
  localparam int RPT_B      = 57;
  localparam int RPT_A      = 56;
  localparam int RPT_ONE    = 55;
  localparam int RPT_L      = 54;
  localparam int RPT_R      = 53;
  localparam int RPT_Z      = 52;
  localparam int RPT_DUP    = 51;
  localparam int RPT_DDOWN  = 50;
  localparam int RPT_DRIGHT = 49;
  localparam int RPT_DLEFT  = 48;

  // LSB offsets of the analog bytes
  localparam int OFS_JOYX    = 40;
  localparam int OFS_JOYY    = 32;
  localparam int OFS_CSTICKX = 24;
  localparam int OFS_CSTICKY = 16;
  localparam int OFS_LANALOG = 8;
  localparam int OFS_RANALOG = 0;

  function automatic logic report_ok(input logic [63:0] rpt);
    return (rpt[63:61] == 3'b000) && rpt[RPT_ONE];
  endfunction

  function automatic logic [11:0] extract_buttons(input logic [63:0] rpt);
    logic [11:0] b;
    b             = '0;
    b[BTN_Y]      = rpt[RPT_Y];
    b[BTN_X]      = rpt[RPT_X];
    b[BTN_B]      = rpt[RPT_B];
    b[BTN_A]      = rpt[RPT_A];
    b[BTN_L]      = rpt[RPT_L];
    b[BTN_R]      = rpt[RPT_R];
    b[BTN_DLEFT]  = rpt[RPT_DLEFT];
    b[BTN_DUP]    = rpt[RPT_DUP];
    b[BTN_DDOWN]  = rpt[RPT_DDOWN];
    b[BTN_DRIGHT] = rpt[RPT_DRIGHT];
    b[BTN_Z]      = rpt[RPT_Z];
    b[BTN_START]  = rpt[RPT_START];
    return b;
  endfunction

endpackage

// File: rtl/gc_report_decoder_if.sv
// Report-in / decoded-state-out bundle for gc_report_decoder.
// master = report source and state consumer, slave = the decoder.
interface gc_report_decoder_if;
  logic        ReportValid;
  logic [63:0] Report;
  logic        Recal;
  logic [11:0] Buttons;
  logic [11:0] Pressed;
  logic [7:0]  joyX;
  logic [7:0]  joyY;
  logic [7:0]  cstickX;
  logic [7:0]  cstickY;
  logic [7:0]  lButton;
  logic [7:0]  rButton;
  logic        Connected;
  logic        BadFrame;

  modport master (
    output ReportValid, Report, Recal,
    input  Buttons, Pressed, joyX, joyY, cstickX, cstickY,
           lButton, rButton, Connected, BadFrame
  );

  modport slave (
    input  ReportValid, Report, Recal,
    output Buttons, Pressed, joyX, joyY, cstickX, cstickY,
           lButton, rButton, Connected, BadFrame
  );
endinterface

// File: rtl/gc_stick_cal.sv
// One stick axis: 4-sample origin accumulator plus offset/clamp (and optional deadzone under GC_DEADZONE_EN).
// o_stick is combinational from i_raw and the stored origin; the caller registers it.
import gc_pkg::*;

module gc_stick_cal #(
  parameter int unsigned DEADZONE = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_first,
  input  logic       i_add,
  input  logic       i_load,
  input  logic [7:0] i_raw,
  output logic [7:0] o_stick
);

  logic [9:0]        r_acc;
  logic [7:0]        r_origin;
  logic [9:0]        w_acc_next;
  logic signed [8:0] w_d;
  logic signed [9:0] w_sum;
  logic [7:0]        w_clamped;

  assign w_acc_next = r_acc + {2'b00, i_raw};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_acc    <= '0;
      r_origin <= STICK_NEUTRAL;
    end else if (i_first) begin
      r_acc <= {2'b00, i_raw};
    end else if (i_add) begin
      r_acc <= w_acc_next;
    end else if (i_load) begin
      r_acc    <= '0;
      r_origin <= w_acc_next[9:2];
    end
  end

  // Widen before adding so 128+d can never wrap; saturate both ends
  assign w_d   = $signed({1'b0, i_raw}) - $signed({1'b0, r_origin});
  assign w_sum = 10'sd128 + {w_d[8], w_d};

  always_comb begin
    w_clamped = w_sum[7:0];
    if (w_sum[9]) begin
      w_clamped = 8'h00;
    end else if (w_sum[8]) begin
      w_clamped = 8'hFF;
    end
  end

`ifdef GC_DEADZONE_EN
  logic [8:0] w_mag;
  assign w_mag   = w_d[8] ? (~w_d + 9'd1) : w_d;
  assign o_stick = (32'(w_mag) < DEADZONE) ? STICK_NEUTRAL : w_clamped;
`else
  assign o_stick = w_clamped;
`endif

endmodule

// File: rtl/gc_report_decoder.sv
// Decodes 64-bit controller reports into buttons, edge pulses, calibrated sticks and link status.
// Outputs register 1 cycle after a good strobe; optional stick deadzone built when GC_DEADZONE_EN is defined.
import gc_pkg::*;

module gc_report_decoder #(
  parameter int unsigned STALE_CYCLES = 1_000_000,
  parameter int unsigned DEADZONE     = 8
) (
  input logic               Clk,
  input logic               Reset,
  gc_report_decoder_if.slave bus
);

  localparam int STALE_W = $clog2(STALE_CYCLES + 1);

  gc_state_t          r_state;
  logic [1:0]         r_cnt;
  logic [STALE_W-1:0] r_stale;
  logic [11:0]        r_buttons;
  logic [11:0]        r_pressed;
  logic [7:0]         r_joyx, r_joyy, r_cstickx, r_csticky;
  logic [7:0]         r_lbutton, r_rbutton;
  logic               r_connected;
  logic               r_bad;

  logic        w_good;
  logic        w_bad;
  logic        w_stale_hit;
  logic        w_neutral;
  logic        w_first;
  logic        w_add;
  logic        w_load;
  logic [11:0] w_buttons;
  logic [7:0]  w_joyx, w_joyy, w_cstickx, w_csticky;

  assign w_good      = bus.ReportValid && report_ok(bus.Report);
  assign w_bad       = bus.ReportValid && !w_good;
  assign w_stale_hit = !w_good && (r_stale == STALE_W'(STALE_CYCLES - 1));
  assign w_neutral   = bus.Recal || w_stale_hit;
  assign w_buttons   = extract_buttons(bus.Report);

  // A CALIB count of 0 only follows a Recal with no report, so it also starts a fresh sum
  assign w_first = w_good && (bus.Recal || (r_state == ST_WAIT) ||
                              (r_state == ST_CALIB && r_cnt == 2'd0));
  assign w_add   = w_good && !bus.Recal && (r_state == ST_CALIB) &&
                   (r_cnt == 2'd1 || r_cnt == 2'd2);
  assign w_load  = w_good && !bus.Recal && (r_state == ST_CALIB) && (r_cnt == 2'd3);

  gc_stick_cal #(.DEADZONE(DEADZONE)) u_cal_joyx (
    .Clk(Clk), .Reset(Reset), .i_first(w_first), .i_add(w_add), .i_load(w_load),
    .i_raw(bus.Report[OFS_JOYX +: 8]), .o_stick(w_joyx)
  );
  gc_stick_cal #(.DEADZONE(DEADZONE)) u_cal_joyy (
    .Clk(Clk), .Reset(Reset), .i_first(w_first), .i_add(w_add), .i_load(w_load),
    .i_raw(bus.Report[OFS_JOYY +: 8]), .o_stick(w_joyy)
  );
  gc_stick_cal #(.DEADZONE(DEADZONE)) u_cal_cstickx (
    .Clk(Clk), .Reset(Reset), .i_first(w_first), .i_add(w_add), .i_load(w_load),
    .i_raw(bus.Report[OFS_CSTICKX +: 8]), .o_stick(w_cstickx)
  );
  gc_stick_cal #(.DEADZONE(DEADZONE)) u_cal_csticky (
    .Clk(Clk), .Reset(Reset), .i_first(w_first), .i_add(w_add), .i_load(w_load),
    .i_raw(bus.Report[OFS_CSTICKY +: 8]), .o_stick(w_csticky)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_WAIT;
      r_cnt       <= '0;
      r_stale     <= '0;
      r_buttons   <= '0;
      r_pressed   <= '0;
      r_joyx      <= STICK_NEUTRAL;
      r_joyy      <= STICK_NEUTRAL;
      r_cstickx   <= STICK_NEUTRAL;
      r_csticky   <= STICK_NEUTRAL;
      r_lbutton   <= '0;
      r_rbutton   <= '0;
      r_connected <= 1'b0;
      r_bad       <= 1'b0;
    end else begin
      r_bad     <= w_bad;
      r_pressed <= '0;
      r_stale   <= (w_good || w_stale_hit) ? '0 : r_stale + STALE_W'(1);

      if (bus.Recal) begin
        r_state     <= ST_CALIB;
        r_cnt       <= w_good ? 2'd1 : 2'd0;
        r_connected <= 1'b0;
      end else if (w_good) begin
        unique case (r_state)
          ST_WAIT: begin
            r_state <= ST_CALIB;
            r_cnt   <= 2'd1;
          end
          ST_CALIB: begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state     <= ST_RUN;
              r_connected <= 1'b1;
            end
          end
          ST_RUN: begin
            r_buttons <= w_buttons;
            r_pressed <= w_buttons & ~r_buttons;
            r_joyx    <= w_joyx;
            r_joyy    <= w_joyy;
            r_cstickx <= w_cstickx;
            r_csticky <= w_csticky;
            r_lbutton <= bus.Report[OFS_LANALOG +: 8];
            r_rbutton <= bus.Report[OFS_RANALOG +: 8];
          end
          default: r_state <= ST_WAIT;
        endcase
      end else if (w_stale_hit) begin
        r_state     <= ST_WAIT;
        r_connected <= 1'b0;
      end

      if (w_neutral) begin
        r_buttons <= '0;
        r_joyx    <= STICK_NEUTRAL;
        r_joyy    <= STICK_NEUTRAL;
        r_cstickx <= STICK_NEUTRAL;
        r_csticky <= STICK_NEUTRAL;
        r_lbutton <= '0;
        r_rbutton <= '0;
      end
    end
  end

  assign bus.Buttons   = r_buttons;
  assign bus.Pressed   = r_pressed;
  assign bus.joyX      = r_joyx;
  assign bus.joyY      = r_joyy;
  assign bus.cstickX   = r_cstickx;
  assign bus.cstickY   = r_csticky;
  assign bus.lButton   = r_lbutton;
  assign bus.rButton   = r_rbutton;
  assign bus.Connected = r_connected;
  assign bus.BadFrame  = r_bad;

endmodule

// File: doc/gc_report_decoder.md
GC_REPORT_DECODER -- requirements
Module: gc_report_decoder

Interface
REQ-001 Parameter STALE_CYCLES, default 1_000_000: Clk cycles without a good report before disconnect is declared.
REQ-002 Parameter DEADZONE, default 8: stick deviation magnitude, in raw counts, treated as centred.
REQ-003 Port Clk, input, 1: single system clock, 50 MHz; all logic is clocked on its rising edge.
REQ-004 Port Reset, input, 1: reset, synchronous and active-high.
REQ-005 Port ReportValid, input, 1: one-cycle strobe; Report holds a complete controller response.
REQ-006 Port Report, input, 64: raw response, MSB first. Byte layout: [63:56] = 0,0,0,START,Y,X,B,A. [55:48] = 1,L,R,Z,dUP,dDOWN,dRIGHT,dLEFT. Then joyX, joyY, cstickX, cstickY, lAnalog, rAnalog.
REQ-007 Port Recal, input, 1: level or pulse; requests stick re-calibration.
REQ-008 Port Buttons, output, 12: {START,Z,dRIGHT,dDOWN,dUP,dLEFT,R,L,A,B,X,Y}, bit 11 to bit 0.
REQ-009 Port Pressed, output, 12: one-cycle rising-edge pulses, same bit order as Buttons.
REQ-010 Ports joyX, joyY, cstickX, cstickY, output, 8 each: calibrated sticks, offset binary, centre 8'h80.
REQ-011 Ports lButton, rButton, output, 8 each: analog triggers, passed through uncalibrated.
REQ-012 Port Connected, output, 1: high while in RUN.
REQ-013 Port BadFrame, output, 1: one-cycle pulse for each rejected report.

Function
REQ-014 A report is good when Report[63:61]==3'b000 and Report[55]==1; otherwise it is dropped, BadFrame pulses, and state is unchanged.
REQ-015 FSM states: WAIT (initial), CALIB, RUN.
REQ-016 WAIT to CALIB on the first good report; that report is calibration sample 0.
REQ-017 CALIB takes 4 good reports, counted by a 2-bit counter. It sums each stick into a 10-bit accumulator, sets origin = sum>>2, then moves to RUN on the 4th sample.
REQ-018 In RUN, each good report updates all outputs exactly 1 cycle after its ReportValid strobe (registered).
REQ-019 Stick arithmetic: d = raw - origin as a 9-bit signed value; out = clamp(128 + d, 0, 255). No wrap-around is permitted.
REQ-020 In WAIT and CALIB, Buttons, Pressed, and triggers are 0, sticks are 8'h80, and Connected is 0.
REQ-021 Pressed[i] = new Buttons[i] & ~previous Buttons[i], asserted in the same cycle the new Buttons value appears. No pulses occur on the WAIT/CALIB to RUN transition.
REQ-022 A stale counter clears on every good report. When it reaches STALE_CYCLES, FSM goes to WAIT, outputs go to neutral values, and the origin is kept.
REQ-023 Recal in any state restarts CALIB with count 0, and outputs go to neutral values.
REQ-024 If Recal and a good report occur in the same cycle, Recal wins and that report is sample 0.
REQ-025 If a stale timeout and a good report occur in the same cycle, the report wins and the counter clears.

Reset
REQ-026 Reset forces: state WAIT, origins 8'h80, accumulators, counters and Pressed 0, all outputs at neutral values of REQ-020, and BadFrame 0.
REQ-027 Reset asserted mid-CALIB or mid-RUN takes effect on the next edge. A ReportValid in the same cycle is ignored.

Configuration
REQ-028 Macro GC_DEADZONE_EN defined: if |d| < DEADZONE the stick output is exactly 8'h80; otherwise REQ-019 applies unchanged.
REQ-029 Macro GC_DEADZONE_EN undefined: no deadzone logic is built, the DEADZONE parameter is ignored, and REQ-019 applies to all values.

Structure
REQ-030 Package gc_pkg holds the FSM state enum, the button bit-index constants, the report byte offsets, and the neutral stick constant 8'h80.
REQ-031 One sub-module, gc_stick_cal, is instantiated 4 times. Each instance holds the origin accumulator and computes the clamp and the deadzone.

Verification
REQ-032 Bench covers: Reset, then 4 good reports with joyX=8'h70 -> Connected=1 after 4th; a 5th report with joyX=8'h70 -> joyX=8'h80.
REQ-033 Bench covers: after calibration with origin 8'h70, raw joyX=8'hFF -> 8'hFF (clamped); raw 8'h00 -> 8'h10.
REQ-034 Bench covers: good report with A=1 following A=0 -> Pressed[3] high for exactly 1 cycle; the next identical report -> Pressed=0.
REQ-035 Bench covers: Report[55]=0 -> BadFrame pulses once and outputs are unchanged.
REQ-036 Bench covers: no reports for STALE_CYCLES in RUN -> Connected=0 and sticks 8'h80; Recal plus a simultaneous good report -> CALIB count restarts at 1.
REQ-037 Bench covers, with GC_DEADZONE_EN defined: origin 8'h80, raw 8'h87 -> 8'h80; raw 8'h88 -> 8'h88.
